// File: rtl/control_hs.sv
// Multi-cycle RV32 control FSM with memory handshake and bus watchdog.
// Define MULDIV_EN to route OP/bit25 through the multiply/divide unit.
module control_hs #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       bit20,
  input  logic       bit25,
  input  logic       bit30,
  input  logic       cmp_out,
  input  logic       mem_ready,
  input  logic       md_done,
  output logic       pc_load,
  output logic       reg_re,
  output logic       reg_we,
  output logic       reg_rs_sel,
  output logic       alu_sel1,
  output logic [1:0] alu_sel2,
  output logic [4:0] alu_op,
  output logic [1:0] reg_wd_sel,
  output logic       mem_addr_sel,
  output logic [2:0] mem_read_op,
  output logic [1:0] mem_write_op,
  output logic       mem_valid,
  output logic       inst_load,
  output logic       alu_reg_load,
  output logic       next_pc_sel,
  output logic       md_start,
  output logic       halt,
  output logic [1:0] halt_cause
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] LW    = 3'b010;
  localparam logic [2:0] LNONE = 3'b111;
  localparam logic [1:0] SNONE = 2'b11;

  localparam logic [1:0] CAUSE_EBREAK = 2'd0;
  localparam logic [1:0] CAUSE_ILL    = 2'd1;
  localparam logic [1:0] CAUSE_BUS    = 2'd2;

  localparam int unsigned W =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [W-1:0] TMO_LAST =
    W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    FETCH          = 4'd0,
    INST_LOAD      = 4'd1,
    DECODE         = 4'd2,
    FETCH_REG      = 4'd3,
    ALU_OP_IMM     = 4'd4,
    ALU_OP         = 4'd5,
    ALU_R1_ADD_IMM = 4'd6,
    ALU_TO_RF      = 4'd7,
    COND_BRANCH    = 4'd8,
    JALR_ALU       = 4'd9,
    MEM_READ       = 4'd10,
    MEM_WRITE      = 4'd11,
    MEM_TO_RF      = 4'd12,
`ifdef MULDIV_EN
    MD_START       = 4'd13,
    MD_WAIT        = 4'd14,
`endif
    HALT           = 4'd15
  } state_t;

  state_t       state, state_d;
  logic [W-1:0] wd_cnt, wd_cnt_d;
  logic [1:0]   cause_d;
  logic         wd_expire;
  logic         mem_wait;

  logic is_load, is_misc, is_opimm, is_auipc, is_store;
  logic is_op, is_lui, is_branch, is_jalr, is_jal, is_system;

  assign is_load   = (opcode == OPC_LOAD);
  assign is_misc   = (opcode == OPC_MISC);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_store  = (opcode == OPC_STORE);
  assign is_op     = (opcode == OPC_OP);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_system = (opcode == OPC_SYSTEM);

`ifdef MULDIV_EN
  logic unused_in;
  assign unused_in = bit20;
`else
  logic unused_in;
  assign unused_in = ^{bit20, md_done};
`endif

  assign wd_expire = (MEM_TIMEOUT != 0) && (wd_cnt == TMO_LAST);

  // Counter runs only while a memory state waits on itself.
  assign mem_wait = (state_d == state) &&
                    (state == FETCH || state == MEM_READ ||
                     state == MEM_WRITE);
  assign wd_cnt_d = mem_wait ? wd_cnt + W'(1) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      wd_cnt     <= '0;
      halt_cause <= CAUSE_EBREAK;
    end else begin
      state      <= state_d;
      wd_cnt     <= wd_cnt_d;
      halt_cause <= cause_d;
    end
  end

  always_comb begin
    pc_load      = 1'b0;
    reg_re       = 1'b0;
    reg_we       = 1'b0;
    reg_rs_sel   = 1'b0;
    alu_sel1     = 1'b0;
    alu_sel2     = 2'd0;
    alu_op       = 5'd0;
    reg_wd_sel   = 2'd0;
    mem_addr_sel = 1'b0;
    mem_read_op  = LNONE;
    mem_write_op = SNONE;
    mem_valid    = 1'b0;
    inst_load    = 1'b0;
    alu_reg_load = 1'b0;
    next_pc_sel  = 1'b0;
    md_start     = 1'b0;
    halt         = 1'b0;
    state_d      = state;
    cause_d      = halt_cause;

    case (state)
      FETCH: begin
        mem_valid    = 1'b1;
        mem_read_op  = LW;
        alu_sel1     = 1'b1;
        alu_sel2     = 2'd2;
        alu_reg_load = 1'b1;
        if (mem_ready) begin
          state_d = INST_LOAD;
        end else if (wd_expire) begin
          state_d = HALT;
          cause_d = CAUSE_BUS;
        end
      end
      INST_LOAD: begin
        inst_load = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        unique case (1'b1)
          is_opimm, is_lui: begin
            reg_re      = 1'b1;
            pc_load     = 1'b1;
            next_pc_sel = 1'b1;
            state_d     = is_lui ? ALU_R1_ADD_IMM : ALU_OP_IMM;
          end
          is_op, is_store: begin
`ifndef MULDIV_EN
            if (is_op && bit25) begin
              state_d = HALT;
              cause_d = CAUSE_ILL;
            end else
`endif
            begin
              reg_re      = 1'b1;
              reg_rs_sel  = 1'b1;
              pc_load     = 1'b1;
              next_pc_sel = 1'b1;
              state_d     = FETCH_REG;
            end
          end
          is_auipc: begin
            pc_load      = 1'b1;
            next_pc_sel  = 1'b1;
            alu_sel1     = 1'b1;
            alu_sel2     = 2'd1;
            alu_reg_load = 1'b1;
            state_d      = ALU_TO_RF;
          end
          is_branch: begin
            pc_load      = 1'b1;
            next_pc_sel  = 1'b1;
            reg_re       = 1'b1;
            reg_rs_sel   = 1'b1;
            alu_sel1     = 1'b1;
            alu_sel2     = 2'd1;
            alu_reg_load = 1'b1;
            state_d      = FETCH_REG;
          end
          is_jal: begin
            reg_we   = 1'b1;
            pc_load  = 1'b1;
            alu_sel1 = 1'b1;
            alu_sel2 = 2'd1;
            state_d  = FETCH;
          end
          is_jalr: begin
            reg_we  = 1'b1;
            reg_re  = 1'b1;
            state_d = JALR_ALU;
          end
          is_load: begin
            pc_load     = 1'b1;
            next_pc_sel = 1'b1;
            reg_re      = 1'b1;
            state_d     = ALU_R1_ADD_IMM;
          end
          is_misc: begin
            pc_load     = 1'b1;
            next_pc_sel = 1'b1;
            state_d     = FETCH;
          end
          is_system: begin
            state_d = HALT;
            cause_d = CAUSE_EBREAK;
          end
          default: begin
            state_d = HALT;
            cause_d = CAUSE_ILL;
          end
        endcase
      end
      FETCH_REG: begin
        reg_re = 1'b1;
        unique case (1'b1)
          is_branch: state_d = COND_BRANCH;
          is_store:  state_d = ALU_R1_ADD_IMM;
`ifdef MULDIV_EN
          is_op:     state_d = bit25 ? MD_START : ALU_OP;
`else
          is_op:     state_d = ALU_OP;
`endif
          default:   state_d = FETCH;
        endcase
      end
      ALU_OP_IMM: begin
        alu_op = {1'b0, (funct3 == 3'b101) ? bit30 : 1'b0,
                  funct3};
        alu_sel2     = 2'd1;
        alu_reg_load = 1'b1;
        state_d      = ALU_TO_RF;
      end
      ALU_OP: begin
        alu_op       = {1'b0, bit30, funct3};
        alu_reg_load = 1'b1;
        state_d      = ALU_TO_RF;
      end
      ALU_R1_ADD_IMM: begin
        alu_sel2     = 2'd1;
        alu_reg_load = 1'b1;
        unique case (1'b1)
          is_lui:   state_d = ALU_TO_RF;
          is_load:  state_d = MEM_READ;
          is_store: state_d = MEM_WRITE;
          default:  state_d = FETCH;
        endcase
      end
      ALU_TO_RF: begin
        reg_we  = 1'b1;
        state_d = FETCH;
      end
      COND_BRANCH: begin
        pc_load     = cmp_out;
        next_pc_sel = 1'b1;
        alu_op      = {2'b10, funct3};
        state_d     = FETCH;
      end
      JALR_ALU: begin
        pc_load  = 1'b1;
        alu_sel2 = 2'd1;
        state_d  = FETCH;
      end
      MEM_READ: begin
        mem_valid    = 1'b1;
        mem_addr_sel = 1'b1;
        mem_read_op  = funct3;
        if (mem_ready) begin
          state_d = MEM_TO_RF;
        end else if (wd_expire) begin
          state_d = HALT;
          cause_d = CAUSE_BUS;
        end
      end
      MEM_WRITE: begin
        mem_valid    = 1'b1;
        mem_addr_sel = 1'b1;
        mem_write_op = funct3[1:0];
        if (mem_ready) begin
          state_d = FETCH;
        end else if (wd_expire) begin
          state_d = HALT;
          cause_d = CAUSE_BUS;
        end
      end
      MEM_TO_RF: begin
        reg_we     = 1'b1;
        reg_wd_sel = 2'd1;
        state_d    = FETCH;
      end
`ifdef MULDIV_EN
      MD_START: begin
        md_start = 1'b1;
        state_d  = MD_WAIT;
      end
      MD_WAIT: begin
        if (md_done) begin
          reg_we     = 1'b1;
          reg_wd_sel = 2'd2;
          state_d    = FETCH;
        end
      end
`endif
      HALT: begin
        halt = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_control_hs.sv
// Directed bench for control_hs (MEM_TIMEOUT=4).
// Works with or without MULDIV_EN defined.
module tb_control_hs;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       bit20, bit25, bit30;
  logic       cmp_out, mem_ready, md_done;
  logic       pc_load, reg_re, reg_we, reg_rs_sel;
  logic       alu_sel1;
  logic [1:0] alu_sel2;
  logic [4:0] alu_op;
  logic [1:0] reg_wd_sel;
  logic       mem_addr_sel;
  logic [2:0] mem_read_op;
  logic [1:0] mem_write_op;
  logic       mem_valid, inst_load, alu_reg_load;
  logic       next_pc_sel, md_start, halt;
  logic [1:0] halt_cause;

  control_hs #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .opcode(opcode), .funct3(funct3),
    .bit20(bit20), .bit25(bit25), .bit30(bit30),
    .cmp_out(cmp_out), .mem_ready(mem_ready),
    .md_done(md_done),
    .pc_load(pc_load), .reg_re(reg_re),
    .reg_we(reg_we), .reg_rs_sel(reg_rs_sel),
    .alu_sel1(alu_sel1), .alu_sel2(alu_sel2),
    .alu_op(alu_op), .reg_wd_sel(reg_wd_sel),
    .mem_addr_sel(mem_addr_sel),
    .mem_read_op(mem_read_op),
    .mem_write_op(mem_write_op),
    .mem_valid(mem_valid), .inst_load(inst_load),
    .alu_reg_load(alu_reg_load),
    .next_pc_sel(next_pc_sel), .md_start(md_start),
    .halt(halt), .halt_cause(halt_cause)
  );

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // All outputs except halt_cause, MSB first.
  logic [25:0] obs;
  assign obs = {pc_load, reg_re, reg_we, reg_rs_sel,
                alu_sel1, alu_sel2, alu_op, reg_wd_sel,
                mem_addr_sel, mem_read_op, mem_write_op,
                mem_valid, inst_load, alu_reg_load,
                next_pc_sel, md_start, halt};

  localparam logic [25:0] FETCH_V = {
    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 5'd0, 2'd0,
    1'b0, 3'd2, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [25:0] HALT_V = {
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 2'd0,
    1'b0, 3'd7, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  int n_chk = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    go();
    go();
    reset = 1'b0;
    #1;
  endtask

  task automatic fetch_to_decode(input logic [6:0] op,
                                 input logic [2:0] f3,
                                 input logic b25,
                                 input logic b30);
    opcode    = op;
    funct3    = f3;
    bit25     = b25;
    bit30     = b30;
    mem_ready = 1'b1;
    #1;
    check("fetch_vec", obs, FETCH_V);
    go();
    mem_ready = 1'b0;
    #1;
    check("inst_load", inst_load, 1);
    go();
  endtask

  task automatic do_load(input logic [2:0] f3, input int waits);
    fetch_to_decode(OPC_LOAD, f3, 1'b0, 1'b0);
    check("ld_dec_pc", pc_load, 1);
    check("ld_dec_re", reg_re, 1);
    go();
    check("ld_add_load", alu_reg_load, 1);
    check("ld_add_sel2", alu_sel2, 1);
    go();
    for (int i = 0; i <= waits; i++) begin
      mem_ready = (i == waits);
      #1;
      check("ld_valid", mem_valid, 1);
      check("ld_asel", mem_addr_sel, 1);
      check("ld_rop", mem_read_op, f3);
      check("ld_we_early", reg_we, 0);
      go();
    end
    mem_ready = 1'b0;
    #1;
    check("ld_valid_end", mem_valid, 0);
    check("ld_we", reg_we, 1);
    check("ld_wd", reg_wd_sel, 1);
    go();
    check("ld_back", obs, FETCH_V);
  endtask

  task automatic do_branch(input logic [2:0] f3,
                           input logic [4:0] exp_op);
    fetch_to_decode(OPC_BRANCH, f3, 1'b0, 1'b0);
    check("br_dec_pc", pc_load, 1);
    check("br_dec_load", alu_reg_load, 1);
    check("br_dec_sel1", alu_sel1, 1);
    check("br_dec_sel2", alu_sel2, 1);
    check("br_dec_rs", reg_rs_sel, 1);
    go();
    check("br_fr_re", reg_re, 1);
    go();
    cmp_out = 1'b0;
    #1;
    check("br_pc_c0", pc_load, 0);
    cmp_out = 1'b1;
    #1;
    check("br_pc_c1", pc_load, 1);
    check("br_nps", next_pc_sel, 1);
    check("br_op", alu_op, exp_op);
    go();
    cmp_out = 1'b0;
    #1;
    check("br_back", obs, FETCH_V);
  endtask

  initial begin
    reset = 1'b1;
    opcode = '0;
    funct3 = '0;
    bit20 = 1'b0;
    bit25 = 1'b0;
    bit30 = 1'b0;
    cmp_out = 1'b0;
    mem_ready = 1'b0;
    md_done = 1'b0;
    do_reset();
    check("rst_vec", obs, FETCH_V);
    check("rst_cause", halt_cause, 0);

    // ADDI with bit30 set: bit30 must not reach alu_op
    fetch_to_decode(OPC_OPIMM, 3'b000, 1'b0, 1'b1);
    check("addi_dec_pc", pc_load, 1);
    check("addi_dec_re", reg_re, 1);
    check("addi_dec_nps", next_pc_sel, 1);
    check("addi_dec_we", reg_we, 0);
    go();
    check("addi_op", alu_op, 5'b00000);
    check("addi_sel2", alu_sel2, 1);
    check("addi_load", alu_reg_load, 1);
    check("addi_we_early", reg_we, 0);
    go();
    check("addi_we", reg_we, 1);
    check("addi_wd", reg_wd_sel, 0);
    go();
    check("addi_back", obs, FETCH_V);

    fetch_to_decode(OPC_OPIMM, 3'b101, 1'b0, 1'b1);
    go();
    check("srai_op", alu_op, 5'b01101);
    go();
    go();

    fetch_to_decode(OPC_OP, 3'b000, 1'b0, 1'b1);
    check("sub_dec_rs", reg_rs_sel, 1);
    check("sub_dec_pc", pc_load, 1);
    go();
    check("sub_fr_rs", reg_rs_sel, 0);
    check("sub_fr_re", reg_re, 1);
    go();
    check("sub_op", alu_op, 5'b01000);
    check("sub_sel2", alu_sel2, 0);
    go();
    check("sub_we", reg_we, 1);
    go();
    check("sub_back", obs, FETCH_V);

    // ready on the 4th wait cycle coincides with expiry
    do_load(3'b010, 3);
    do_load(3'b100, 0);

    fetch_to_decode(OPC_STORE, 3'b001, 1'b0, 1'b0);
    check("sh_dec_rs", reg_rs_sel, 1);
    go();
    mem_ready = 1'b1;
    #1;
    check("sh_fr_re", reg_re, 1);
    go();
    check("sh_add_load", alu_reg_load, 1);
    check("sh_add_valid", mem_valid, 0);
    go();
    mem_ready = 1'b0;
    #1;
    check("sh_valid", mem_valid, 1);
    check("sh_wop", mem_write_op, 1);
    check("sh_rop", mem_read_op, 7);
    check("sh_asel", mem_addr_sel, 1);
    go();
    mem_ready = 1'b1;
    #1;
    check("sh_wop_hold", mem_write_op, 1);
    go();
    mem_ready = 1'b0;
    #1;
    check("sh_back", obs, FETCH_V);

    do_branch(3'b000, 5'b10000);
    do_branch(3'b001, 5'b10001);

    fetch_to_decode(OPC_JAL, 3'b000, 1'b0, 1'b0);
    check("jal_we", reg_we, 1);
    check("jal_pc", pc_load, 1);
    check("jal_nps", next_pc_sel, 0);
    go();
    check("jal_back", obs, FETCH_V);

    fetch_to_decode(OPC_JALR, 3'b000, 1'b0, 1'b0);
    check("jalr_we", reg_we, 1);
    check("jalr_re", reg_re, 1);
    check("jalr_dec_pc", pc_load, 0);
    go();
    check("jalr_pc", pc_load, 1);
    check("jalr_nps", next_pc_sel, 0);
    check("jalr_sel2", alu_sel2, 1);
    go();
    check("jalr_back", obs, FETCH_V);

    fetch_to_decode(OPC_LUI, 3'b000, 1'b0, 1'b0);
    check("lui_re", reg_re, 1);
    check("lui_pc", pc_load, 1);
    go();
    check("lui_sel2", alu_sel2, 1);
    check("lui_load", alu_reg_load, 1);
    go();
    check("lui_we", reg_we, 1);
    go();
    check("lui_back", obs, FETCH_V);

    fetch_to_decode(OPC_AUIPC, 3'b000, 1'b0, 1'b0);
    check("auipc_pc", pc_load, 1);
    check("auipc_load", alu_reg_load, 1);
    check("auipc_sel1", alu_sel1, 1);
    check("auipc_sel2", alu_sel2, 1);
    go();
    check("auipc_we", reg_we, 1);
    go();
    check("auipc_back", obs, FETCH_V);

    fetch_to_decode(OPC_MISC, 3'b000, 1'b0, 1'b0);
    check("fence_pc", pc_load, 1);
    go();
    check("fence_back", obs, FETCH_V);

    fetch_to_decode(OPC_OP, 3'b000, 1'b1, 1'b0);
`ifdef MULDIV_EN
    check("md_dec_pc", pc_load, 1);
    go();
    go();
    md_done = 1'b1;
    #1;
    check("md_start", md_start, 1);
    check("md_start_we", reg_we, 0);
    go();
    md_done = 1'b0;
    #1;
    for (int i = 0; i < 33; i++) begin
      check("md_wait_start", md_start, 0);
      check("md_wait_we", reg_we, 0);
      go();
    end
    md_done = 1'b1;
    #1;
    check("md_we", reg_we, 1);
    check("md_wd", reg_wd_sel, 2);
    go();
    md_done = 1'b0;
    #1;
    check("md_back", obs, FETCH_V);
`else
    check("md_dec_pc", pc_load, 0);
    check("md_dec_we", reg_we, 0);
    go();
    check("md_halt", obs, HALT_V);
    check("md_cause", halt_cause, 1);
    do_reset();
`endif

    fetch_to_decode(7'b0000000, 3'b000, 1'b0, 1'b0);
    check("ill_pc", pc_load, 0);
    check("ill_we", reg_we, 0);
    go();
    check("ill_halt", obs, HALT_V);
    check("ill_cause", halt_cause, 1);
    mem_ready = 1'b1;
    go();
    go();
    check("ill_hold", obs, HALT_V);
    check("ill_hold_cause", halt_cause, 1);
    mem_ready = 1'b0;
    do_reset();
    check("ill_rst_vec", obs, FETCH_V);
    check("ill_rst_cause", halt_cause, 0);

    bit20 = 1'b1;
    fetch_to_decode(OPC_SYSTEM, 3'b000, 1'b0, 1'b0);
    go();
    check("ebrk_halt", obs, HALT_V);
    check("ebrk_cause", halt_cause, 0);
    bit20 = 1'b0;
    do_reset();

    // watchdog on a stalled fetch
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("wd_wait", obs, FETCH_V);
      go();
    end
    check("wd_halt", obs, HALT_V);
    check("wd_cause", halt_cause, 2);
    do_reset();
    check("wd_rst_vec", obs, FETCH_V);
    check("wd_rst_cause", halt_cause, 0);

    // reset in mid-wait must clear the count
    go();
    go();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check("wd_clr_wait", obs, FETCH_V);
      go();
    end
    mem_ready = 1'b1;
    #1;
    go();
    mem_ready = 1'b0;
    #1;
    check("wd_clr_inst", inst_load, 1);
    check("wd_clr_cause", halt_cause, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/control_hs.md
CONTROL_HS -- requirements
Module: control_hs

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: max memory wait cycles before bus-error halt; 0 disables the watchdog.
REQ-002 SHALL have ports clk in 1 (clock) and reset in 1 (reset, synchronous, active-high); all state updates on posedge clk.
REQ-003 SHALL have inputs opcode 7, funct3 3, bit20 1, bit25 1, bit30 1, cmp_out 1, mem_ready 1 (memory transfer complete), md_done 1 (multiply/divide result valid).
REQ-004 SHALL have outputs pc_load 1, reg_re 1, reg_we 1, reg_rs_sel 1, alu_sel1 1, alu_sel2 2, alu_op 5, reg_wd_sel 2 (0 alu_reg, 1 mem, 2 muldiv), mem_addr_sel 1, mem_read_op 3, mem_write_op 2, mem_valid 1, inst_load 1, alu_reg_load 1, next_pc_sel 1, md_start 1.
REQ-005 SHALL have outputs halt 1 (core stopped) and halt_cause 2 (0 ebreak, 1 illegal instruction, 2 bus timeout).

Function
REQ-006 SHALL implement a 4-bit Moore/Mealy FSM: FETCH, INST_LOAD, DECODE, FETCH_REG, ALU_OP_IMM, ALU_OP, ALU_R1_ADD_IMM, ALU_TO_RF, COND_BRANCH, JALR_ALU, MEM_READ, MEM_WRITE, MEM_TO_RF, MD_START, MD_WAIT, HALT.
REQ-007 Every output not asserted by the current state SHALL be 0, except mem_read_op = LNONE and mem_write_op = SNONE (defs.inc encodings).
REQ-008 FETCH: mem_valid=1, mem_addr_sel=0, mem_read_op=LW, alu_sel1=1, alu_sel2=2, alu_op=0, alu_reg_load=1; stays until mem_ready, then -> INST_LOAD.
REQ-009 INST_LOAD: inst_load=1 -> DECODE; opcode/funct3/bit* are valid from DECODE onward.
REQ-010 DECODE outputs and next states per opcode: OP_IMM, LUI (r1 read, rs_sel 0, pc<=alu_reg) -> ALU_OP_IMM / ALU_R1_ADD_IMM; OP, STORE (rs_sel 1, pc<=alu_reg) -> FETCH_REG; AUIPC (pc<=alu_reg, alu_reg<=pc+imm) -> ALU_TO_RF.
REQ-011 DECODE BRANCH: pc<=alu_reg, read rs2, alu_reg<=pc+imm (sel1=1, sel2=1, op 0) -> FETCH_REG; JAL: reg_we, pc<=pc+imm via next_pc_sel=0 -> FETCH; JALR: reg_we, read rs1 -> JALR_ALU.
REQ-012 DECODE LOAD: pc<=alu_reg, read rs1 -> ALU_R1_ADD_IMM; MISC_MEM: pc<=alu_reg -> FETCH; SYSTEM: -> HALT, cause 0.
REQ-013 DECODE with any other opcode, or OP with bit25=1 while MULDIV_EN undefined: no pc_load, no reg_we -> HALT, cause 1.
REQ-014 FETCH_REG: read rs1 (rs_sel 0); BRANCH -> COND_BRANCH; STORE -> ALU_R1_ADD_IMM; OP -> MD_START if bit25=1, else ALU_OP.
REQ-015 ALU_OP_IMM: alu_op={0, funct3==101 ? bit30 : 0, funct3}, sel1=0, sel2=1, load; ALU_OP: alu_op={0,bit30,funct3}, sel1=0, sel2=0, load; both -> ALU_TO_RF.
REQ-016 ALU_R1_ADD_IMM: alu_reg<=r1+imm; then LUI -> ALU_TO_RF, LOAD -> MEM_READ, STORE -> MEM_WRITE.
REQ-017 ALU_TO_RF: reg_we=1, wd_sel=0 -> FETCH; COND_BRANCH: pc_load=cmp_out, next_pc_sel=1, alu_op={1,0,funct3}, sel1=0, sel2=0 -> FETCH; JALR_ALU: pc<=r1+imm -> FETCH.
REQ-018 MEM_READ: mem_valid=1, mem_addr_sel=1, mem_read_op=funct3 until mem_ready, then -> MEM_TO_RF (reg_we=1, wd_sel=1) -> FETCH.
REQ-019 MEM_WRITE: mem_valid=1, mem_addr_sel=1, mem_write_op=funct3[1:0] until mem_ready, then -> FETCH.
REQ-020 Memory handshake: request fields SHALL stay constant while mem_valid=1 and ready=0; mem_ready in the first valid cycle completes with zero wait; mem_ready while mem_valid=0 SHALL be ignored.
REQ-021 Watchdog: counter clears on every entry to FETCH/MEM_READ/MEM_WRITE, increments each waiting cycle; when MEM_TIMEOUT>0 and MEM_TIMEOUT cycles pass with no mem_ready -> HALT, cause 2; mem_ready in the same cycle as expiry wins.
REQ-022 HALT: halt=1, all other outputs at default, halt_cause held; exit only by reset.

Reset
REQ-023 reset SHALL force FETCH, clear watchdog counter and halt_cause to 0, overriding all other events, including mid-wait and in HALT.
REQ-024 Outputs SHALL equal FETCH values in the first cycle after reset deasserts.

Configuration
REQ-025 Macro MULDIV_EN defined: OP with bit25=1 via MD_START (md_start=1 for one cycle, sel1=0, sel2=0) -> MD_WAIT; on md_done: reg_we=1, wd_sel=2 -> FETCH; md_done in MD_START ignored.
REQ-026 MULDIV_EN undefined: MD_START/MD_WAIT SHALL be absent, md_start tied 0, md_done unused, bit25=1 OP halts with cause 1.

Verification
REQ-027 ADDI with mem_ready at first valid cycle -> FETCH,INST_LOAD,DECODE,ALU_OP_IMM,ALU_TO_RF: 5 cycles, one reg_we.
REQ-028 LW with mem_ready delayed 3 cycles in MEM_READ -> mem_valid high 4 cycles, mem_read_op=funct3 stable, then one reg_we with wd_sel=1.
REQ-029 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> HALT after 4 wait cycles, halt=1, halt_cause=2; reset -> FETCH, cause 0.
REQ-030 BEQ with cmp_out=1 and 0 -> pc_load in COND_BRANCH equals cmp_out, next_pc_sel=1, alu_op=5'b10000.
REQ-031 OP bit25=1: with MULDIV_EN, md_start one pulse, md_done after 33 cycles -> reg_we with wd_sel=2; without it -> HALT, cause 1, no pc_load.
REQ-032 Opcode 7'b0000000 in DECODE -> HALT, cause 1; EBREAK -> HALT, cause 0.
